// File: rtl/pipe_stage_skid_if.sv
// Handshake bundle for one pipeline stage boundary: upstream beat, downstream
// beat, flush and occupancy.
interface pipe_stage_skid_if #(
    parameter int CTRL_W = 8,
    parameter int DATA_W = 96
);
    logic              flush_i;
    logic              valid_i;
    logic              ready_o;
    logic [CTRL_W-1:0] ctrl_i;
    logic [DATA_W-1:0] data_i;
    logic              valid_o;
    logic              ready_i;
    logic [CTRL_W-1:0] ctrl_o;
    logic [DATA_W-1:0] data_o;
    logic [1:0]        occ_o;

    modport master (
        output flush_i, valid_i, ctrl_i, data_i, ready_i,
        input  ready_o, valid_o, ctrl_o, data_o, occ_o
    );

    modport slave (
        input  flush_i, valid_i, ctrl_i, data_i, ready_i,
        output ready_o, valid_o, ctrl_o, data_o, occ_o
    );
endinterface

// File: rtl/pipe_stage_skid.sv
// Pipeline-boundary register with valid/ready, synchronous flush to a NOP
// bubble and an optional second (skid) entry that lets ready_o be registered.
module pipe_stage_skid #(
    parameter int CTRL_W = 8,
    parameter int DATA_W = 96,
    parameter bit SKID   = 1'b1
) (
    input logic             clk_i,
    input logic             rst_i,
    pipe_stage_skid_if.slave bus
);
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    state_t            state_q, state_nxt;
    logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
    logic [DATA_W-1:0] main_data, skid_data;
    logic              accept, xfer;
    logic              ld_main_in, ld_main_skid, ld_skid, clr_main;

    assign accept = bus.valid_i & bus.ready_o;
    assign xfer   = bus.valid_o & bus.ready_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= ST_EMPTY;
        else       state_q <= state_nxt;
    end

    always_comb begin
        state_nxt    = state_q;
        ld_main_in   = 1'b0;
        ld_main_skid = 1'b0;
        ld_skid      = 1'b0;
        clr_main     = 1'b0;
        if (bus.flush_i) begin
            state_nxt = ST_EMPTY;
            clr_main  = 1'b1;
        end else begin
            case (state_q)
                ST_EMPTY: if (accept) begin
                    state_nxt  = ST_FULL;
                    ld_main_in = 1'b1;
                end
                ST_FULL: case ({accept, xfer})
                    2'b10: begin
                        state_nxt = ST_SKID;
                        ld_skid   = 1'b1;
                    end
                    2'b11: ld_main_in = 1'b1;
                    2'b01: begin
                        state_nxt = ST_EMPTY;
                        clr_main  = 1'b1;
                    end
                    default: ;
                endcase
                ST_SKID: if (xfer) begin
                    state_nxt    = ST_FULL;
                    ld_main_skid = 1'b1;
                end
                default: state_nxt = ST_EMPTY;
            endcase
        end
    end

    // data_o keeps its last value when emptied; only ctrl is forced to a NOP
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            main_ctrl <= '0;
            main_data <= '0;
            skid_ctrl <= '0;
            skid_data <= '0;
        end else begin
            if (clr_main) begin
                main_ctrl <= '0;
            end else if (ld_main_in) begin
                main_ctrl <= bus.ctrl_i;
                main_data <= bus.data_i;
            end else if (ld_main_skid) begin
                main_ctrl <= skid_ctrl;
                main_data <= skid_data;
            end
            if (ld_skid) begin
                skid_ctrl <= bus.ctrl_i;
                skid_data <= bus.data_i;
            end else if (ld_main_skid || bus.flush_i) begin
                skid_ctrl <= '0;
                skid_data <= '0;
            end
        end
    end

    assign bus.valid_o = (state_q != ST_EMPTY);
    assign bus.ctrl_o  = main_ctrl;
    assign bus.data_o  = main_data;
    assign bus.occ_o   = state_q;

    generate
        if (SKID) begin : g_skid
            logic rdy_q;
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) rdy_q <= 1'b1;
                else       rdy_q <= (state_nxt != ST_SKID);
            end
            assign bus.ready_o = rdy_q;
        end else begin : g_single
            assign bus.ready_o = ~bus.valid_o | bus.ready_i;
        end
    endgenerate
endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed checks of the skid (SKID=1) and single-entry (SKID=0) variants,
// followed by a randomized run against a reference queue.
module tb_pipe_stage_skid;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    pipe_stage_skid_if #(.CTRL_W(8), .DATA_W(96)) b1 ();
    pipe_stage_skid_if #(.CTRL_W(8), .DATA_W(96)) b0 ();

    pipe_stage_skid #(.CTRL_W(8), .DATA_W(96), .SKID(1'b1)) dut1 (
        .clk_i(clk), .rst_i(rst), .bus(b1)
    );
    pipe_stage_skid #(.CTRL_W(8), .DATA_W(96), .SKID(1'b0)) dut0 (
        .clk_i(clk), .rst_i(rst), .bus(b0)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive1(input logic v, input logic [7:0] c, input logic [95:0] d, input logic r, input logic f);
        b1.valid_i = v; b1.ctrl_i = c; b1.data_i = d; b1.ready_i = r; b1.flush_i = f;
    endtask

    task automatic drive0(input logic v, input logic [7:0] c, input logic [95:0] d, input logic r, input logic f);
        b0.valid_i = v; b0.ctrl_i = c; b0.data_i = d; b0.ready_i = r; b0.flush_i = f;
    endtask

    int          q[$];
    int          seq;
    logic        vi, ri, fl, xf, ac;
    int          occ_m;

    initial begin
        drive1(1'b0, 8'h0, 96'h0, 1'b0, 1'b0);
        drive0(1'b0, 8'h0, 96'h0, 1'b0, 1'b0);
        repeat (3) tick;
        chk("rst_valid", b1.valid_o, 0);
        chk("rst_ctrl",  b1.ctrl_o,  0);
        chk("rst_data",  b1.data_o,  0);
        chk("rst_occ",   b1.occ_o,   0);
        @(negedge clk); rst = 1'b0;
        tick;
        chk("rel_ready", b1.ready_o, 1);

        // first beat after reset, downstream ready
        drive1(1'b1, 8'h5A, 96'h1, 1'b1, 1'b0);
        tick;
        drive1(1'b0, 8'h0, 96'h0, 1'b1, 1'b0);
        chk("s1_valid", b1.valid_o, 1);
        chk("s1_ctrl",  b1.ctrl_o,  8'h5A);
        chk("s1_data",  b1.data_o,  96'h1);
        chk("s1_occ",   b1.occ_o,   1);
        tick;
        chk("s1_drain_valid", b1.valid_o, 0);
        chk("s1_drain_ctrl",  b1.ctrl_o,  0);

        // mid-stream asynchronous reset, sampled between edges
        drive1(1'b1, 8'h33, 96'h9, 1'b0, 1'b0);
        tick;
        drive1(1'b0, 8'h0, 96'h0, 1'b0, 1'b0);
        chk("pre_rst_occ", b1.occ_o, 1);
        #1 rst = 1'b1;
        #1;
        chk("arst_valid", b1.valid_o, 0);
        chk("arst_ctrl",  b1.ctrl_o,  0);
        chk("arst_occ",   b1.occ_o,   0);
        @(negedge clk); rst = 1'b0;
        tick;
        chk("arst_ready", b1.ready_o, 1);

        // full throughput: ten back-to-back beats
        for (int k = 1; k <= 10; k++) begin
            drive1(1'b1, 8'(k), 96'(k), 1'b1, 1'b0);
            #1 chk("tp_ready", b1.ready_o, 1);
            tick;
            chk("tp_data",  b1.data_o,  96'(k));
            chk("tp_valid", b1.valid_o, 1);
            chk("tp_occ",   b1.occ_o,   1);
        end
        drive1(1'b0, 8'h0, 96'h0, 1'b1, 1'b0);
        tick;
        chk("tp_empty", b1.valid_o, 0);

        // back-pressure: A=3, B=4 held, C=5 waits upstream
        drive1(1'b1, 8'h03, 96'h3, 1'b0, 1'b0);
        tick;
        chk("bp_a_occ",   b1.occ_o,   1);
        chk("bp_a_ready", b1.ready_o, 1);
        drive1(1'b1, 8'h04, 96'h4, 1'b0, 1'b0);
        tick;
        chk("bp_b_occ",   b1.occ_o,   2);
        chk("bp_b_ready", b1.ready_o, 0);
        chk("bp_b_data",  b1.data_o,  96'h3);
        drive1(1'b1, 8'h05, 96'h5, 1'b0, 1'b0);
        tick;
        chk("bp_c_occ",  b1.occ_o,  2);
        chk("bp_c_data", b1.data_o, 96'h3);
        drive1(1'b1, 8'h05, 96'h5, 1'b1, 1'b0);
        tick;
        chk("bp_out_b",      b1.data_o,  96'h4);
        chk("bp_out_b_ctrl", b1.ctrl_o,  8'h04);
        chk("bp_out_b_occ",  b1.occ_o,   1);
        chk("bp_out_b_rdy",  b1.ready_o, 1);
        tick;
        drive1(1'b0, 8'h0, 96'h0, 1'b1, 1'b0);
        chk("bp_out_c",       b1.data_o,  96'h5);
        chk("bp_out_c_valid", b1.valid_o, 1);
        tick;
        chk("bp_done", b1.valid_o, 0);

        // flush with two entries held and a beat offered
        drive1(1'b1, 8'h11, 96'h11, 1'b0, 1'b0);
        tick;
        drive1(1'b1, 8'h22, 96'h22, 1'b0, 1'b0);
        tick;
        chk("fl_occ2", b1.occ_o, 2);
        drive1(1'b1, 8'h07, 96'h7, 1'b0, 1'b1);
        tick;
        drive1(1'b0, 8'h0, 96'h0, 1'b1, 1'b0);
        chk("fl_valid", b1.valid_o, 0);
        chk("fl_ctrl",  b1.ctrl_o,  0);
        chk("fl_occ",   b1.occ_o,   0);
        chk("fl_ready", b1.ready_o, 1);
        tick;
        chk("fl_no7_a", b1.valid_o, 0);
        tick;
        chk("fl_no7_b", b1.valid_o, 0);

        // flush while an accept would otherwise happen (ready_o=1)
        drive1(1'b1, 8'h44, 96'h44, 1'b0, 1'b0);
        tick;
        drive1(1'b1, 8'h08, 96'h8, 1'b0, 1'b1);
        tick;
        drive1(1'b0, 8'h0, 96'h0, 1'b0, 1'b0);
        chk("fl1_valid", b1.valid_o, 0);
        chk("fl1_occ",   b1.occ_o,   0);
        tick;
        chk("fl1_no8", b1.valid_o, 0);

        // single-entry variant: combinational ready and same-edge turnover
        drive0(1'b1, 8'h21, 96'h21, 1'b0, 1'b0);
        #1 chk("s0_ready_empty", b0.ready_o, 1);
        tick;
        drive0(1'b1, 8'h99, 96'h99, 1'b0, 1'b0);
        #1;
        chk("s0_ready_stall", b0.ready_o, 0);
        chk("s0_occ1",        b0.occ_o,   1);
        tick;
        chk("s0_hold_data", b0.data_o, 96'h21);
        chk("s0_hold_occ",  b0.occ_o,  1);
        drive0(1'b1, 8'h22, 96'h22, 1'b1, 1'b0);
        #1 chk("s0_ready_go", b0.ready_o, 1);
        tick;
        drive0(1'b0, 8'h0, 96'h0, 1'b1, 1'b0);
        chk("s0_b2b_data",  b0.data_o,  96'h22);
        chk("s0_b2b_valid", b0.valid_o, 1);
        tick;
        chk("s0_empty_valid", b0.valid_o, 0);
        chk("s0_empty_ctrl",  b0.ctrl_o,  0);
        chk("s0_empty_occ",   b0.occ_o,   0);

        // randomized run against a reference queue (SKID=1)
        seq = 100;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            vi = ($urandom_range(0, 3) != 0);
            ri = ($urandom_range(0, 2) != 0);
            fl = ($urandom_range(0, 39) == 0);
            drive1(vi, {1'b1, 7'(seq)}, 96'(seq), ri, fl);
            #1;
            occ_m = q.size();
            chk("rnd_occ",   b1.occ_o,   occ_m);
            chk("rnd_valid", b1.valid_o, (occ_m > 0));
            chk("rnd_ready", b1.ready_o, (occ_m < 2));
            if (occ_m == 0) chk("rnd_nop", b1.ctrl_o, 0);
            xf = (occ_m > 0) && ri;
            ac = vi && (occ_m < 2);
            if (xf) begin
                chk("rnd_data", b1.data_o, 96'(q[0]));
                chk("rnd_ctrl", b1.ctrl_o, {1'b1, 7'(q[0])});
            end
            tick;
            if (fl) begin
                q.delete();
            end else begin
                if (xf) void'(q.pop_front());
                if (ac) begin
                    q.push_back(seq);
                    seq++;
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
